// File: rtl/selector_mensaje_rotativo_pkg.sv
// Shared types and constants for the rotating message selector.
package selector_pkg;

    // Controller states: manual select, auto rotation, frozen rotation, empty mask.
    typedef enum logic [1:0] {
        S_MANUAL = 2'd0,
        S_AUTO   = 2'd1,
        S_PAUSA  = 2'd2,
        S_VACIO  = 2'd3
    } estado_t;

    // Segment level that turns a common-anode segment off; BLANCO defaults to all of these.
    localparam logic BLANCO_BIT = 1'b1;

endpackage

// File: rtl/selector_mensaje_rotativo_buscador.sv
// Circular search for the next enabled channel after the current index.
// With no other enabled channel the current index is returned unchanged.
module buscador_siguiente #(
    parameter int N_MSJ = 4,
    parameter int SEL_W = 2
) (
    input  logic [N_MSJ-1:0] mascara,
    input  logic [SEL_W-1:0] indice,
    output logic [SEL_W-1:0] siguiente
);

    logic encontrado;

    // Scan idx+1 .. idx+N_MSJ (mod N_MSJ); the last candidate is idx itself.
    always_comb begin
        siguiente  = indice;
        encontrado = 1'b0;
        for (int k = 1; k <= N_MSJ; k++) begin
            logic [SEL_W-1:0] cand;
            cand = SEL_W'((int'(indice) + k) % N_MSJ);
            if (!encontrado && mascara[cand]) begin
                siguiente  = cand;
                encontrado = 1'b1;
            end
        end
    end

endmodule

// File: rtl/selector_mensaje_rotativo.sv
// Rotating message selector: shows one of N_MSJ seven-segment patterns,
// chosen manually or rotated automatically across the enabled channels.
module selector_mensaje_rotativo
    import selector_pkg::*;
#(
    parameter int               N_MSJ       = 4,
    parameter int               ANCHO       = 7,
    parameter int               PERMANENCIA = 50_000_000,
    parameter logic [ANCHO-1:0] BLANCO      = {ANCHO{BLANCO_BIT}},
    localparam int              SEL_W       = $clog2(N_MSJ)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_MSJ*ANCHO-1:0] msjs,
    input  logic [N_MSJ-1:0]       habilitado,
    input  logic                   modo,
    input  logic [SEL_W-1:0]       seleccion,
    input  logic                   pausa,
    output logic [ANCHO-1:0]       msj_seleccionado,
    output logic [SEL_W-1:0]       indice_actual,
    output logic                   cambio
);

    localparam int               CNT_W   = $clog2(PERMANENCIA);
    localparam logic [CNT_W-1:0] CNT_FIN = CNT_W'(PERMANENCIA - 1);

    estado_t          estado_q, estado_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ANCHO-1:0] msj_q, msj_d;
    logic             cambio_q;

    logic [SEL_W-1:0] idx_sig;
    logic             sel_ok;
    logic [ANCHO-1:0] canal [N_MSJ];

    // Unflatten the message bus so a channel can be picked by index.
    for (genvar k = 0; k < N_MSJ; k++) begin : g_canal
        assign canal[k] = msjs[k*ANCHO +: ANCHO];
    end

    buscador_siguiente #(
        .N_MSJ (N_MSJ),
        .SEL_W (SEL_W)
    ) u_buscador (
        .mascara   (habilitado),
        .indice    (idx_q),
        .siguiente (idx_sig)
    );

    // Out-of-range selections (non power-of-two N_MSJ) keep the current index.
    assign sel_ok = (int'(seleccion) < N_MSJ);

    // Next-state decision; branch order encodes the per-cycle precedence:
    // empty mask, mode change, pause, then terminal count.
    always_comb begin
        estado_d = estado_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        if (habilitado == '0) begin
            estado_d = S_VACIO;
            cnt_d    = '0;
        end else if (estado_q == S_VACIO) begin
            cnt_d = '0;
            if (modo) begin
                estado_d = S_AUTO;
                // Never resume on a channel that is not enabled.
                if (!habilitado[idx_q]) idx_d = idx_sig;
            end else begin
                estado_d = S_MANUAL;
                if (sel_ok) idx_d = seleccion;
            end
        end else if (estado_q == S_MANUAL) begin
            if (modo) begin
                estado_d = S_AUTO;
                cnt_d    = '0;
            end else if (sel_ok) begin
                idx_d = seleccion;
            end
        end else begin
            if (!modo) begin
                estado_d = S_MANUAL;
                cnt_d    = '0;
            end else if (pausa) begin
                // Freeze counter and index.
                estado_d = S_PAUSA;
            end else begin
                // Release from pause counts on the same cycle, as if never paused.
                estado_d = S_AUTO;
                if (!habilitado[idx_q] || cnt_q == CNT_FIN) begin
                    idx_d = idx_sig;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
        msj_d = (estado_d == S_VACIO) ? BLANCO : canal[idx_d];
    end

    // State, index, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            estado_q <= S_MANUAL;
            idx_q    <= '0;
            cnt_q    <= '0;
            cambio_q <= 1'b0;
            msj_q    <= BLANCO;
        end else begin
            estado_q <= estado_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            cambio_q <= (idx_d != idx_q);
            msj_q    <= msj_d;
        end
    end

    assign msj_seleccionado = msj_q;
    assign indice_actual    = idx_q;
    assign cambio           = cambio_q;

endmodule

// File: tb/tb_selector_mensaje_rotativo.sv
// Directed bench for the rotating message selector (4 channels, dwell of 4).
module tb_selector_mensaje_rotativo;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [27:0] msjs;
    logic [3:0]  habilitado;
    logic        modo;
    logic [1:0]  seleccion;
    logic        pausa;
    logic [6:0]  msj_seleccionado;
    logic [1:0]  indice_actual;
    logic        cambio;

    int checks = 0;
    int errors = 0;

    logic [6:0] MSJ [4] = '{7'h40, 7'h79, 7'h12, 7'h30};
    logic [9:0] obs;
    logic [9:0] esp;

    assign obs = {indice_actual, msj_seleccionado, cambio};

    selector_mensaje_rotativo #(
        .N_MSJ       (4),
        .ANCHO       (7),
        .PERMANENCIA (4)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .msjs             (msjs),
        .habilitado       (habilitado),
        .modo             (modo),
        .seleccion        (seleccion),
        .pausa            (pausa),
        .msj_seleccionado (msj_seleccionado),
        .indice_actual    (indice_actual),
        .cambio           (cambio)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; habilitado = 4'b1111; modo = 1'b0; seleccion = 2'd0; pausa = 1'b0;
        msjs = {MSJ[3], MSJ[2], MSJ[1], MSJ[0]};
        tick(); tick();
        esp = {2'd0, 7'h7F, 1'b0}; checks++;
        if (obs !== esp) begin errors++; $display("FAIL reset: got %h want %h", obs, esp); end
    endtask

    task automatic test_manual();
        reset_n = 1'b1; seleccion = 2'd2;
        tick();
        esp = {2'd2, 7'h12, 1'b1}; checks++;
        if (obs !== esp) begin errors++; $display("FAIL manual_sel2: got %h want %h", obs, esp); end
        tick();
        esp = {2'd2, 7'h12, 1'b0}; checks++;
        if (obs !== esp) begin errors++; $display("FAIL manual_pulse_once: got %h want %h", obs, esp); end
        // Enables are ignored in manual mode.
        habilitado = 4'b0001; seleccion = 2'd3;
        tick();
        esp = {2'd3, 7'h30, 1'b1}; checks++;
        if (obs !== esp) begin errors++; $display("FAIL manual_disabled_ch: got %h want %h", obs, esp); end
        // Message data change shows up after one cycle, no index change.
        msjs[27:21] = 7'h55;
        tick();
        esp = {2'd3, 7'h55, 1'b0}; checks++;
        if (obs !== esp) begin errors++; $display("FAIL msj_latency: got %h want %h", obs, esp); end
        msjs[27:21] = MSJ[3]; seleccion = 2'd0;
        tick();
        esp = {2'd0, 7'h40, 1'b1}; checks++;
        if (obs !== esp) begin errors++; $display("FAIL manual_sel0: got %h want %h", obs, esp); end
    endtask

    task automatic test_auto();
        logic [1:0] exp_idx;
        habilitado = 4'b1111; modo = 1'b1;
        tick();
        esp = {2'd0, 7'h40, 1'b0}; checks++;
        if (obs !== esp) begin errors++; $display("FAIL auto_enter: got %h want %h", obs, esp); end
        for (int s = 1; s <= 4; s++) begin
            exp_idx = 2'(s % 4);
            tick(); tick(); tick();
            checks++;
            if (cambio !== 1'b0 || indice_actual !== 2'(s - 1)) begin
                errors++; $display("FAIL auto_dwell step %0d: got idx=%0d cambio=%b want idx=%0d cambio=0", s, indice_actual, cambio, s - 1);
            end
            tick();
            esp = {exp_idx, MSJ[exp_idx], 1'b1}; checks++;
            if (obs !== esp) begin errors++; $display("FAIL auto_step %0d: got %h want %h", s, obs, esp); end
        end
    endtask

    task automatic test_alterna();
        logic [1:0] seq [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
        habilitado = 4'b1010;
        tick();
        esp = {2'd1, 7'h79, 1'b1}; checks++;
        if (obs !== esp) begin errors++; $display("FAIL alt_skip_disabled: got %h want %h", obs, esp); end
        for (int s = 1; s < 4; s++) begin
            tick(); tick(); tick(); tick();
            esp = {seq[s], MSJ[seq[s]], 1'b1}; checks++;
            if (obs !== esp) begin errors++; $display("FAIL alt_step %0d: got %h want %h", s, obs, esp); end
        end
        tick();
        habilitado = 4'b0010;
        tick();
        esp = {2'd1, 7'h79, 1'b1}; checks++;
        if (obs !== esp) begin errors++; $display("FAIL alt_cur_disabled: got %h want %h", obs, esp); end
        // Sole enabled channel: terminal count passes with no change.
        for (int c = 0; c < 4; c++) begin
            tick();
            esp = {2'd1, 7'h79, 1'b0}; checks++;
            if (obs !== esp) begin errors++; $display("FAIL alt_single cycle %0d: got %h want %h", c, obs, esp); end
        end
        habilitado = 4'b1010;
        tick(); tick(); tick();
        esp = {2'd1, 7'h79, 1'b0}; checks++;
        if (obs !== esp) begin errors++; $display("FAIL alt_cnt_cleared: got %h want %h", obs, esp); end
        tick();
        esp = {2'd3, 7'h30, 1'b1}; checks++;
        if (obs !== esp) begin errors++; $display("FAIL alt_resume: got %h want %h", obs, esp); end
    endtask

    task automatic test_pausa();
        int bad;
        tick(); tick();
        pausa = 1'b1;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (indice_actual !== 2'd3 || cambio !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL pausa_hold: got %0d bad cycles want 0", bad); end
        pausa = 1'b0;
        tick();
        esp = {2'd3, 7'h30, 1'b0}; checks++;
        if (obs !== esp) begin errors++; $display("FAIL pausa_release1: got %h want %h", obs, esp); end
        tick();
        esp = {2'd1, 7'h79, 1'b1}; checks++;
        if (obs !== esp) begin errors++; $display("FAIL pausa_release2: got %h want %h", obs, esp); end
    endtask

    task automatic test_vacio();
        habilitado = 4'b0000;
        tick();
        esp = {2'd1, 7'h7F, 1'b0}; checks++;
        if (obs !== esp) begin errors++; $display("FAIL vacio_blank: got %h want %h", obs, esp); end
        tick();
        esp = {2'd1, 7'h7F, 1'b0}; checks++;
        if (obs !== esp) begin errors++; $display("FAIL vacio_hold: got %h want %h", obs, esp); end
        habilitado = 4'b0001;
        tick();
        esp = {2'd0, 7'h40, 1'b1}; checks++;
        if (obs !== esp) begin errors++; $display("FAIL vacio_exit: got %h want %h", obs, esp); end
        habilitado = 4'b0011;
        tick(); tick(); tick();
        esp = {2'd0, 7'h40, 1'b0}; checks++;
        if (obs !== esp) begin errors++; $display("FAIL vacio_cnt0: got %h want %h", obs, esp); end
        tick();
        esp = {2'd1, 7'h79, 1'b1}; checks++;
        if (obs !== esp) begin errors++; $display("FAIL vacio_next: got %h want %h", obs, esp); end
    endtask

    task automatic test_reset_mid();
        tick(); tick(); tick();
        reset_n = 1'b0; modo = 1'b0; seleccion = 2'd2;
        tick();
        esp = {2'd0, 7'h7F, 1'b0}; checks++;
        if (obs !== esp) begin errors++; $display("FAIL reset_mid: got %h want %h", obs, esp); end
        reset_n = 1'b1;
        tick();
        esp = {2'd2, 7'h12, 1'b1}; checks++;
        if (obs !== esp) begin errors++; $display("FAIL reset_release: got %h want %h", obs, esp); end
    endtask

    task automatic test_modo();
        pausa = 1'b1; seleccion = 2'd1;
        tick();
        esp = {2'd1, 7'h79, 1'b1}; checks++;
        if (obs !== esp) begin errors++; $display("FAIL modo_pausa_ignored: got %h want %h", obs, esp); end
        pausa = 1'b0; modo = 1'b1; habilitado = 4'b1111; seleccion = 2'd3;
        tick();
        esp = {2'd1, 7'h79, 1'b0}; checks++;
        if (obs !== esp) begin errors++; $display("FAIL modo_to_auto: got %h want %h", obs, esp); end
        tick(); tick(); tick();
        esp = {2'd1, 7'h79, 1'b0}; checks++;
        if (obs !== esp) begin errors++; $display("FAIL modo_auto_dwell: got %h want %h", obs, esp); end
        tick();
        esp = {2'd2, 7'h12, 1'b1}; checks++;
        if (obs !== esp) begin errors++; $display("FAIL modo_auto_step: got %h want %h", obs, esp); end
        modo = 1'b0;
        tick();
        esp = {2'd2, 7'h12, 1'b0}; checks++;
        if (obs !== esp) begin errors++; $display("FAIL modo_to_manual: got %h want %h", obs, esp); end
        tick();
        esp = {2'd3, 7'h30, 1'b1}; checks++;
        if (obs !== esp) begin errors++; $display("FAIL modo_manual_follow: got %h want %h", obs, esp); end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_auto();
        test_alterna();
        test_pausa();
        test_vacio();
        test_reset_mid();
        test_modo();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
